// File: rtl/mac_vec_acc.sv
// Streaming LANES-wide fixed-point multiply-accumulate with per-frame bias, rounding and saturation.
// Pipeline: products -> lane sum -> frame accumulator -> quantised output, with one global stall.
module mac_vec_acc #(
  parameter int LANES     = 4,
  parameter int IW_M      = 4,
  parameter int QW_M      = 8,
  parameter int IW_X      = 4,
  parameter int QW_X      = 8,
  parameter int IW_B      = 4,
  parameter int QW_B      = 8,
  parameter int IW_Y      = 4,
  parameter int QW_Y      = 8,
  parameter int ACC_GUARD = 8,
  parameter int ROUND     = 0,
  parameter int SAT       = 1
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic [LANES*(IW_M+QW_M)-1:0]    m_in,
  input  logic [LANES*(IW_X+QW_X)-1:0]    x_in,
  input  logic [IW_B+QW_B-1:0]            b_in,
  input  logic                            in_valid,
  input  logic                            in_last,
  output logic                            in_ready,
  output logic [IW_Y+QW_Y-1:0]            y_out,
  output logic                            y_valid,
  input  logic                            y_ready,
  output logic                            ovf_out
);

  localparam int WL_M    = IW_M + QW_M;
  localparam int WL_X    = IW_X + QW_X;
  localparam int WL_B    = IW_B + QW_B;
  localparam int WL_Y    = IW_Y + QW_Y;
  localparam int WL_PROD = WL_M + WL_X;
  localparam int QW_PROD = QW_M + QW_X;
  localparam int WSUM    = WL_PROD + $clog2(LANES);
  localparam int ACC_W   = WSUM + ACC_GUARD;
  localparam int QW_S    = (QW_PROD > QW_B) ? QW_PROD : QW_B;
  localparam int IA      = ACC_W - QW_PROD;
  localparam int IS      = ((IA > IW_B) ? IA : IW_B) + 1;
  localparam int WS      = IS + QW_S;
  localparam int SH      = (QW_S > QW_Y) ? (QW_S - QW_Y) : 0;
  localparam int PAD     = (QW_Y > QW_S) ? (QW_Y - QW_S) : 0;
  localparam int WQ0     = WS + 1 + PAD;
  localparam int WQ      = (WQ0 > WL_Y + 1) ? WQ0 : (WL_Y + 1);
  localparam int RSH     = (SH > 0) ? (SH - 1) : 0;
  localparam bit RND_EN  = (ROUND != 0) && (SH > 0);
  localparam logic signed [WQ-1:0] RND = RND_EN ? (WQ'(1) <<< RSH) : '0;
  localparam logic [WL_Y-1:0] Y_MAX = {1'b0, {(WL_Y-1){1'b1}}};
  localparam logic [WL_Y-1:0] Y_MIN = {1'b1, {(WL_Y-1){1'b0}}};

  logic adv;
  assign adv      = !y_valid || y_ready;
  assign in_ready = adv;

  // Stage 1: per-lane products
  logic signed [WL_PROD-1:0] prod_comb [LANES];
  logic signed [WL_PROD-1:0] prod_reg  [LANES];
  logic                      v1_reg, l1_reg;
  logic signed [WL_B-1:0]    b1_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [WL_PROD-1:0] m_ext, x_ext;
      assign m_ext         = WL_PROD'($signed(m_in[gi*WL_M +: WL_M]));
      assign x_ext         = WL_PROD'($signed(x_in[gi*WL_X +: WL_X]));
      assign prod_comb[gi] = m_ext * x_ext;
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < LANES; k++) prod_reg[k] <= '0;
      v1_reg <= 1'b0;
      l1_reg <= 1'b0;
      b1_reg <= '0;
    end else if (adv) begin
      for (int k = 0; k < LANES; k++) prod_reg[k] <= prod_comb[k];
      v1_reg <= in_valid;
      l1_reg <= in_last;
      b1_reg <= $signed(b_in);
    end
  end

  // Stage 2: lane sum
  logic signed [WSUM-1:0] lane_sum;
  logic signed [WSUM-1:0] s2_reg;
  logic                   v2_reg, l2_reg;
  logic signed [WL_B-1:0] b2_reg;

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) lane_sum = lane_sum + WSUM'(prod_reg[k]);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s2_reg <= '0;
      v2_reg <= 1'b0;
      l2_reg <= 1'b0;
      b2_reg <= '0;
    end else if (adv) begin
      s2_reg <= lane_sum;
      v2_reg <= v1_reg;
      l2_reg <= l1_reg;
      b2_reg <= b1_reg;
    end
  end

  // Stage 3: frame accumulator; bubbles leave both acc and the first-beat flag alone
  logic signed [ACC_W-1:0] acc_reg;
  logic                    first_reg;
  logic                    v3_reg, l3_reg;
  logic signed [WL_B-1:0]  b3_reg;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc_reg   <= '0;
      first_reg <= 1'b1;
      v3_reg    <= 1'b0;
      l3_reg    <= 1'b0;
      b3_reg    <= '0;
    end else if (adv) begin
      v3_reg <= v2_reg;
      l3_reg <= l2_reg;
      b3_reg <= b2_reg;
      if (v2_reg) begin
        acc_reg   <= first_reg ? ACC_W'(s2_reg) : acc_reg + ACC_W'(s2_reg);
        first_reg <= l2_reg;
      end
    end
  end

  // Output quantisation: align, add bias, round/floor to QW_Y, then fit integer range
  logic signed [WS-1:0]   acc_al, b_al, full_sum;
  logic signed [WQ-1:0]   q_val;
  logic signed [WL_Y-1:0] q_trunc;
  logic                   fits;
  logic [WL_Y-1:0]        y_next;
  logic                   ovf_next;

  always_comb begin
    acc_al   = WS'(acc_reg) <<< (QW_S - QW_PROD);
    b_al     = WS'(b3_reg) <<< (QW_S - QW_B);
    full_sum = acc_al + b_al;
    q_val    = ((WQ'(full_sum) <<< PAD) + RND) >>> SH;
    q_trunc  = q_val[WL_Y-1:0];
    fits     = (q_val == {{(WQ-WL_Y){q_trunc[WL_Y-1]}}, q_trunc});
    ovf_next = !fits;
    y_next   = q_trunc;
    if (!fits && (SAT != 0)) y_next = q_val[WQ-1] ? Y_MIN : Y_MAX;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      y_out   <= '0;
      y_valid <= 1'b0;
      ovf_out <= 1'b0;
    end else if (adv) begin
      if (v3_reg && l3_reg) begin
        y_out   <= y_next;
        ovf_out <= ovf_next;
        y_valid <= 1'b1;
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_vec_acc.sv
// Directed bench for mac_vec_acc: three instances (default, round-half-up, wrap) share one stimulus stream.
module tb_mac_vec_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] m, x;
  logic [11:0] b;
  logic        in_valid, in_last, y_ready;

  logic [11:0] y_a, y_r, y_w;
  logic        yv_a, yv_r, yv_w;
  logic        ovf_a, ovf_r, ovf_w;
  logic        rdy_a, rdy_r, rdy_w;

  int vectors     = 0;
  int miscompares = 0;

  logic [12:0] qa[$], qr[$], qw[$];

  always #5 clk = ~clk;

  mac_vec_acc dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .m_in(m), .x_in(x), .b_in(b),
    .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_a),
    .y_out(y_a), .y_valid(yv_a), .y_ready(y_ready), .ovf_out(ovf_a)
  );

  mac_vec_acc #(.ROUND(1)) dut_r (
    .clk_in(clk), .rst_n_in(rst_n), .m_in(m), .x_in(x), .b_in(b),
    .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_r),
    .y_out(y_r), .y_valid(yv_r), .y_ready(y_ready), .ovf_out(ovf_r)
  );

  mac_vec_acc #(.SAT(0)) dut_w (
    .clk_in(clk), .rst_n_in(rst_n), .m_in(m), .x_in(x), .b_in(b),
    .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_w),
    .y_out(y_w), .y_valid(yv_w), .y_ready(y_ready), .ovf_out(ovf_w)
  );

  // Inputs change only just after posedge, so the negedge view equals the handshake at the next edge
  always @(negedge clk) begin
    if (rst_n && y_ready) begin
      if (yv_a) qa.push_back({ovf_a, y_a});
      if (yv_r) qr.push_back({ovf_r, y_r});
      if (yv_w) qw.push_back({ovf_w, y_w});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [47:0] mv, input logic [47:0] xv, input logic [11:0] bv,
                      input logic last);
    bit r;
    int n;
    m = mv; x = xv; b = bv; in_valid = 1'b1; in_last = last;
    n = 0;
    do begin
      @(negedge clk);
      r = rdy_a;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 200);
    if (!r) begin
      vectors++;
      miscompares++;
      $display("FAIL send: in_ready observed 0 expected 1 within 200 cycles");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input logic [12:0] ea, input logic [12:0] er,
                              input logic [12:0] ew);
    int n;
    n = 0;
    while ((qa.size() == 0 || qr.size() == 0 || qw.size() == 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (qa.size() == 0 || qr.size() == 0 || qw.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: observed no result expected one within 100 cycles", tag);
    end else begin
      chk({tag, "/def"},   32'(qa.pop_front()), 32'(ea));
      chk({tag, "/round"}, 32'(qr.pop_front()), 32'(er));
      chk({tag, "/wrap"},  32'(qw.pop_front()), 32'(ew));
    end
  endtask

  task automatic clear_q();
    qa.delete(); qr.delete(); qw.delete();
  endtask

  function automatic logic [47:0] lane0(input logic [11:0] v);
    return {36'h0, v};
  endfunction

  initial begin
    logic [11:0] stall_exp [4];
    stall_exp = '{12'h080, 12'h110, 12'h1A0, 12'h230};

    rst_n = 1'b0; m = '0; x = '0; b = '0;
    in_valid = 1'b0; in_last = 1'b0; y_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/y_out",    32'(y_a),   32'h0);
    chk("reset/y_valid",  32'(yv_a),  32'h0);
    chk("reset/ovf",      32'(ovf_a), 32'h0);
    chk("reset/in_ready", 32'(rdy_a), 32'h1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-beat frame and 3-edge latency
    send({4{12'h100}}, {4{12'h080}}, 12'h040, 1'b1);
    chk("lat/e0", 32'(yv_a), 32'h0);
    @(posedge clk); #1;
    chk("lat/e1", 32'(yv_a), 32'h0);
    @(posedge clk); #1;
    chk("lat/e2", 32'(yv_a), 32'h0);
    @(posedge clk); #1;
    chk("lat/e3",       32'(yv_a),  32'h1);
    chk("lat/y_def",    32'(y_a),   32'h240);
    chk("lat/ovf_def",  32'(ovf_a), 32'h0);
    chk("lat/y_round",  32'(y_r),   32'h240);
    chk("lat/y_wrap",   32'(y_w),   32'h240);
    @(posedge clk); #1;
    clear_q();

    // Two back-to-back 3-beat frames; bias on non-last beats must be ignored
    for (int f = 0; f < 2; f++) begin
      send(lane0(12'h100), lane0(12'h100), 12'h123, 1'b0);
      send(lane0(12'h100), lane0(12'h100), 12'h123, 1'b0);
      send(lane0(12'h100), lane0(12'h100), 12'hF00, 1'b1);
    end
    expect_frame("frame3a", 13'h0200, 13'h0200, 13'h0200);
    expect_frame("frame3b", 13'h0200, 13'h0200, 13'h0200);

    // Integer overflow: 196.0 saturates or wraps to 4.0
    send({4{12'h700}}, {4{12'h700}}, 12'h000, 1'b1);
    expect_frame("ovf", 13'h17FF, 13'h17FF, 13'h1400);

    // Rounding of +/-2^-9
    send(lane0(12'h001), lane0(12'h080), 12'h000, 1'b1);
    send(lane0(12'hFFF), lane0(12'h080), 12'h000, 1'b1);
    expect_frame("rnd_pos", 13'h0000, 13'h0001, 13'h0000);
    expect_frame("rnd_neg", 13'h0FFF, 13'h0000, 13'h0FFF);

    // Continuous 2-beat frames with a 5-cycle downstream stall on the first result
    clear_q();
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          send(lane0(12'h100), lane0(12'(12'h040 * (i + 1))), 12'(12'h010 * i), 1'b0);
          send(lane0(12'h100), lane0(12'(12'h040 * (i + 1))), 12'(12'h010 * i), 1'b1);
        end
      end
      begin
        int n;
        n = 0;
        while (!yv_a && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        y_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(posedge clk); #1;
          chk("stall/in_ready", 32'(rdy_a), 32'h0);
          chk("stall/y_valid",  32'(yv_a),  32'h1);
          chk("stall/y_hold",   32'(y_a),   32'h080);
        end
        y_ready = 1'b1;
      end
    join
    for (int i = 0; i < 4; i++)
      expect_frame("stream", {1'b0, stall_exp[i]}, {1'b0, stall_exp[i]}, {1'b0, stall_exp[i]});

    // Async reset mid-frame: outputs clear at once and the partial frame is discarded
    send(lane0(12'h100), lane0(12'h100), 12'h000, 1'b0);
    send(lane0(12'h100), lane0(12'h100), 12'h000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst/y_def",   32'(y_a),   32'h0);
    chk("arst/y_round", 32'(y_r),   32'h0);
    chk("arst/y_valid", 32'(yv_a),  32'h0);
    chk("arst/ovf",     32'(ovf_a), 32'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
    for (int i = 0; i < 4; i++)
      send(lane0(12'h100), lane0(12'h100), 12'h000, (i == 3));
    expect_frame("post_rst", 13'h0400, 13'h0400, 13'h0400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
